// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: state encoding and
// architectural constants also used by the program counter.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam logic [31:0] RESET_PC  = 32'h00000000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry instruction+PC holding register used when decode stalls while a
// fetch is still landing. Flush beats load, load beats drain.
module fetch_skid_buffer
   import fetch_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        drain_i,
   input  logic        flush_i,
   input  logic [31:0] data_i,
   input  logic [31:0] pc_i,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic [31:0] pc_o
);

   logic        valid_q;
   logic [31:0] data_q;
   logic [31:0] pc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= NOP_INSTR;
         pc_q    <= RESET_PC;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         pc_q    <= pc_i;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch engine between the PC, the instruction memory port and decode:
// one outstanding request, output register plus one-entry skid buffer.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] PC,
   input  logic        Redirect,
   output logic        Fetch_Stall,
   output logic        Mem_Req,
   output logic [31:0] Mem_Addr,
   input  logic        Mem_Ack,
   input  logic [31:0] Mem_RData,
   output logic [31:0] Instr,
   output logic [31:0] Instr_PC,
   output logic        Instr_Valid,
   input  logic        Instr_Ready,
   output logic        Fetch_Fault
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   fetch_state_t state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              fault_q, fault_d;
   logic              drop_q, drop_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic        skid_valid;
   logic [31:0] skid_data;
   logic [31:0] skid_pc;
   logic        out_free;
   logic        ack_live;
   logic        ack_take;
   logic        skid_load;
   logic        skid_drain;

   // Output register can accept new data if empty or consumed this cycle.
   assign out_free   = ~instr_valid_q | Instr_Ready;
   assign ack_live   = (state_q == ST_WAIT) & Mem_Ack & ~drop_q;
   assign ack_take   = ack_live & ~Redirect;
   assign skid_load  = ack_take & ~out_free;
   assign skid_drain = skid_valid & out_free & ~Redirect;

   fetch_skid_buffer u_skid (
      .clk_i   (CLK),
      .rst_i   (Reset),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .flush_i (Redirect),
      .data_i  (Mem_RData),
      .pc_i    (mem_addr_q),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .pc_o    (skid_pc)
   );

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fault_d       = fault_q;
      drop_d        = drop_q;
      cnt_d         = cnt_q;

      if (instr_valid_q && Instr_Ready) begin
         instr_valid_d = 1'b0;
      end
      if (ack_take && out_free) begin
         instr_d       = Mem_RData;
         instr_pc_d    = mem_addr_q;
         instr_valid_d = 1'b1;
      end else if (skid_drain) begin
         instr_d       = skid_data;
         instr_pc_d    = skid_pc;
         instr_valid_d = 1'b1;
      end
      if (Redirect) begin
         instr_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // During a redirect PC still shows the old address, so wait a cycle.
            if (!Redirect) begin
               if (PC[1:0] != 2'b00) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else if (!skid_valid) begin
                  state_d    = ST_WAIT;
                  mem_req_d  = 1'b1;
                  mem_addr_d = PC;
                  cnt_d      = '0;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (Mem_Ack) begin
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
               state_d   = skid_load ? ST_HOLD : ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
               fault_d   = 1'b1;
               state_d   = ST_FAULT;
            end else if (Redirect) begin
               drop_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (Redirect || skid_drain) begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (Redirect) begin
               fault_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= RESET_PC;
         instr_q       <= NOP_INSTR;
         instr_pc_q    <= RESET_PC;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
         drop_q        <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
         drop_q        <= drop_d;
         cnt_q         <= cnt_d;
      end
   end

   assign Fetch_Stall = ~ack_live;
   assign Mem_Req     = mem_req_q;
   assign Mem_Addr    = mem_addr_q;
   assign Instr       = instr_q;
   assign Instr_PC    = instr_pc_q;
   assign Instr_Valid = instr_valid_q;
   assign Fetch_Fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a PC/memory environment, a directed
// stimulus sequence that queues expected deliveries, and a decoupled monitor.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] PC;
   logic        Redirect;
   logic        Fetch_Stall;
   logic        Mem_Req;
   logic [31:0] Mem_Addr;
   logic        Mem_Ack;
   logic [31:0] Mem_RData;
   logic [31:0] Instr;
   logic [31:0] Instr_PC;
   logic        Instr_Valid;
   logic        Instr_Ready;
   logic        Fetch_Fault;

   instr_fetch_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .PC          (PC),
      .Redirect    (Redirect),
      .Fetch_Stall (Fetch_Stall),
      .Mem_Req     (Mem_Req),
      .Mem_Addr    (Mem_Addr),
      .Mem_Ack     (Mem_Ack),
      .Mem_RData   (Mem_RData),
      .Instr       (Instr),
      .Instr_PC    (Instr_PC),
      .Instr_Valid (Instr_Valid),
      .Instr_Ready (Instr_Ready),
      .Fetch_Fault (Fetch_Fault)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   int          lat      = 0;
   bit          mem_en   = 1'b1;
   logic [31:0] redir_tgt = 32'h0;
   logic [31:0] pc_nxt;
   int          wcnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h00500093 ^ {a[23:0], 8'h00};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %08h want %08h", name, act, exp);
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      sb_q.push_back(e);
   endtask

   // Checks and drives happen 2 units after the falling edge.
   task automatic cyc();
      @(negedge CLK);
      #2;
   endtask

   task automatic do_reset();
      Reset    = 1'b1;
      Redirect = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic wait_req(input logic [31:0] a, input string name);
      int n;
      n = 0;
      while (!(Mem_Req === 1'b1 && Mem_Addr === a) && n < 40) begin
         cyc();
         n++;
      end
      check({name, "_req"}, {31'b0, Mem_Req}, 32'd1);
      check({name, "_addr"}, Mem_Addr, a);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         cyc();
         n++;
      end
      check(name, sb_q.size(), 32'd0);
      sb_q.delete();
   endtask

   // Memory responder and program counter partner.
   initial begin
      Mem_Ack   = 1'b0;
      Mem_RData = 32'h0;
      PC        = RESET_PC;
      forever begin
         @(negedge CLK);
         if (Mem_Req === 1'b1 && mem_en) begin
            if (wcnt == lat) begin
               Mem_Ack   = 1'b1;
               Mem_RData = mem_word(Mem_Addr);
               wcnt      = 0;
            end else begin
               Mem_Ack = 1'b0;
               wcnt++;
            end
         end else begin
            Mem_Ack = 1'b0;
            wcnt    = 0;
         end
         #3;
         pc_nxt = Redirect ? redir_tgt : (Fetch_Stall ? PC : PC + 32'd4);
         @(posedge CLK);
         #1;
         PC = Reset ? RESET_PC : pc_nxt;
      end
   end

   // Monitor: every accepted instruction is compared with the queue head.
   initial begin
      forever begin
         @(negedge CLK);
         #3;
         if (Instr_Valid === 1'b1 && Instr_Ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_instr: got pc %08h instr %08h want no delivery", Instr_PC, Instr);
            end else begin
               mon_e = sb_q.pop_front();
               $display("deliver pc=%08h instr=%08h", Instr_PC, Instr);
               check("sb_instr", Instr, mon_e.instr);
               check("sb_pc", Instr_PC, mon_e.pc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      Reset       = 1'b1;
      Redirect    = 1'b0;
      Instr_Ready = 1'b1;

      // Reset values
      cyc();
      check("rst_mem_req", {31'b0, Mem_Req}, 32'd0);
      check("rst_mem_addr", Mem_Addr, 32'h0);
      check("rst_instr", Instr, 32'h00000013);
      check("rst_instr_pc", Instr_PC, 32'h0);
      check("rst_valid", {31'b0, Instr_Valid}, 32'd0);
      check("rst_fault", {31'b0, Fetch_Fault}, 32'd0);
      check("rst_stall", {31'b0, Fetch_Stall}, 32'd1);

      // Zero-wait memory, PC 0/4/8
      do_reset();
      lat = 0; mem_en = 1'b1; Instr_Ready = 1'b1;
      push(32'h00500093, 32'h0);
      push(32'h00500493, 32'h4);
      push(32'h00500893, 32'h8);
      Reset = 1'b0;
      cyc();
      check("zw_c1_req", {31'b0, Mem_Req}, 32'd1);
      check("zw_c1_addr", Mem_Addr, 32'h0);
      check("zw_c1_stall", {31'b0, Fetch_Stall}, 32'd0);
      cyc();
      check("zw_c2_req", {31'b0, Mem_Req}, 32'd0);
      check("zw_c2_valid", {31'b0, Instr_Valid}, 32'd1);
      check("zw_c2_stall", {31'b0, Fetch_Stall}, 32'd1);
      cyc();
      check("zw_c3_addr", Mem_Addr, 32'h4);
      cyc();
      cyc();
      check("zw_c5_addr", Mem_Addr, 32'h8);
      wait_drain("zw_drain");

      // Three-cycle memory latency
      do_reset();
      lat = 3;
      push(32'h00500093, 32'h0);
      Reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         check("lat3_stall", {31'b0, Fetch_Stall}, 32'd1);
      end
      cyc();
      check("lat3_ack_stall", {31'b0, Fetch_Stall}, 32'd0);
      cyc();
      check("lat3_instr", Instr, 32'h00500093);
      check("lat3_valid", {31'b0, Instr_Valid}, 32'd1);
      wait_drain("lat3_drain");

      // Backpressure across two fetches
      do_reset();
      lat = 0; Instr_Ready = 1'b0;
      push(32'h00500093, 32'h0);
      push(32'h00500493, 32'h4);
      Reset = 1'b0;
      cyc(); cyc(); cyc();
      check("bp_c3_addr", Mem_Addr, 32'h4);
      check("bp_c3_stall", {31'b0, Fetch_Stall}, 32'd0);
      cyc();
      check("bp_hold_req", {31'b0, Mem_Req}, 32'd0);
      check("bp_hold_pc", Instr_PC, 32'h0);
      cyc();
      check("bp_hold_req2", {31'b0, Mem_Req}, 32'd0);
      Instr_Ready = 1'b1;
      wait_drain("bp_drain");

      // Redirect while waiting on address 8
      do_reset();
      lat = 2;
      push(32'h00500093, 32'h0);
      push(32'h00500493, 32'h4);
      push(32'h00504093, 32'h40);
      Reset = 1'b0;
      wait_req(32'h8, "rd_wait8");
      Redirect = 1'b1; redir_tgt = 32'h40;
      cyc();
      Redirect = 1'b0;
      check("rd_req_held", {31'b0, Mem_Req}, 32'd1);
      check("rd_addr_held", Mem_Addr, 32'h8);
      cyc();
      check("rd_drop_stall", {31'b0, Fetch_Stall}, 32'd1);
      check("rd_drop_valid", {31'b0, Instr_Valid}, 32'd0);
      wait_req(32'h40, "rd_fetch40");
      wait_drain("rd_drain");

      // Misaligned PC fault, cleared by redirect
      do_reset();
      lat = 0;
      Redirect = 1'b1; redir_tgt = 32'h2;
      Reset = 1'b0;
      cyc();
      Redirect = 1'b0;
      cyc();
      check("mis_fault", {31'b0, Fetch_Fault}, 32'd1);
      check("mis_req", {31'b0, Mem_Req}, 32'd0);
      cyc();
      check("mis_req2", {31'b0, Mem_Req}, 32'd0);
      push(32'h00510093, 32'h100);
      Redirect = 1'b1; redir_tgt = 32'h100;
      cyc();
      Redirect = 1'b0;
      check("mis_clear", {31'b0, Fetch_Fault}, 32'd0);
      wait_req(32'h100, "mis_fetch100");
      wait_drain("mis_drain");

      // Memory timeout, then asynchronous reset mid-fault
      do_reset();
      lat = 0; Instr_Ready = 1'b0;
      Redirect = 1'b1; redir_tgt = 32'h44;
      Reset = 1'b0;
      cyc();
      Redirect = 1'b0;
      wait_req(32'h44, "to_fetch44");
      mem_en = 1'b0;
      wait_req(32'h48, "to_fetch48");
      repeat (15) cyc();
      check("to_last_req", {31'b0, Mem_Req}, 32'd1);
      check("to_last_fault", {31'b0, Fetch_Fault}, 32'd0);
      cyc();
      check("to_req_drop", {31'b0, Mem_Req}, 32'd0);
      check("to_fault", {31'b0, Fetch_Fault}, 32'd1);
      check("to_stall", {31'b0, Fetch_Stall}, 32'd1);
      check("to_held_pc", Instr_PC, 32'h44);
      check("to_held_instr", Instr, 32'h00504493);
      check("to_held_valid", {31'b0, Instr_Valid}, 32'd1);
      Reset = 1'b1;
      #1;
      check("ar_mem_req", {31'b0, Mem_Req}, 32'd0);
      check("ar_mem_addr", Mem_Addr, 32'h0);
      check("ar_instr", Instr, 32'h00000013);
      check("ar_instr_pc", Instr_PC, 32'h0);
      check("ar_valid", {31'b0, Instr_Valid}, 32'd0);
      check("ar_fault", {31'b0, Fetch_Fault}, 32'd0);
      cyc();
      mem_en = 1'b1;

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
